// File: rtl/cla_div_pkg.sv
// Shared constants and types for the CLA restoring divider.
package cla_div_pkg;

  // Default operand width of the arithmetic lab datapath
  localparam int DEF_WIDTH = 5;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Step counter must hold 0..w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/cla_subtractor.sv
// Carry-look-ahead subtractor: diff = a + ~b + 1, cout = 1 means no borrow.
module cla_subtractor #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   carry;

  assign g        = a & ~b;
  assign p        = a ^ ~b;
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_carry
      logic c_bit;

      // Flattened look-ahead term: carry into bit gi+1 from generates and the +1 carry-in
      always_comb begin
        logic prop;
        prop  = 1'b0;
        c_bit = 1'b1;
        for (int j = 0; j <= gi; j++) c_bit = c_bit & p[j];
        for (int j = 0; j <= gi; j++) begin
          prop = g[j];
          for (int k = j + 1; k <= gi; k++) prop = prop & p[k];
          c_bit = c_bit | prop;
        end
      end

      assign carry[gi+1] = c_bit;
      assign diff[gi]    = p[gi] ^ carry[gi];
    end
  endgenerate

  assign cout = carry[W];

endmodule

// File: rtl/cla_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// trial subtraction done by a (WIDTH+1)-bit carry-look-ahead subtractor.
module cla_restoring_divider
  import cla_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int STEP_W = cnt_width(WIDTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]        state_reg, state_next;
  logic [STEP_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH:0]    r_reg, r_next;
  logic [WIDTH-1:0]  q_reg, q_next;
  logic [WIDTH-1:0]  d_reg, d_next;
  logic [WIDTH-1:0]  quot_reg, quot_next;
  logic [WIDTH-1:0]  rem_reg, rem_next;
  logic              dbz_reg, dbz_next;

  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    step_r;
  logic              no_borrow;

  // Partial remainder is always below the divisor, so the shift never loses a bit
  assign shifted = (r_reg << 1) | (WIDTH + 1)'(q_reg[WIDTH-1]);

  cla_subtractor #(.W(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, d_reg}),
    .diff (trial),
    .cout (no_borrow)
  );

  assign step_r = no_borrow ? trial : shifted;

  // Next-state, datapath step and result capture
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          q_next   = dividend;
          d_next   = divisor;
          r_next   = '0;
          cnt_next = '0;
          if (divisor == '0) begin
            state_next = ST_DONE;
            quot_next  = '1;
            rem_next   = dividend;
            dbz_next   = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        r_next   = step_r;
        q_next   = {q_reg[WIDTH-2:0], no_borrow};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == STEP_W'(WIDTH - 1)) begin
          state_next = ST_DONE;
          quot_next  = {q_reg[WIDTH-2:0], no_borrow};
          rem_next   = step_r[WIDTH-1:0];
          dbz_next   = 1'b0;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      r_reg     <= r_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_cla_restoring_divider.sv
// Directed bench for cla_restoring_divider with hand-computed results.
module tb_cla_restoring_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] dividend;
  logic [4:0] divisor;
  logic       busy;
  logic       done;
  logic [4:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int vec_count;
  int miss_count;

  cla_restoring_divider #(.WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One division: start sampled on E0, lat counts edges after E0 until done is seen
  task automatic do_div(input string name, input logic [4:0] a, input logic [4:0] b,
                        input int eq, input int er, input int edbz, input int elat);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    check({name, "_busy"}, busy, 1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, elat);
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dbz"}, div_by_zero, edbz);
    @(negedge clk);
    check({name, "_done_once"}, done, 0);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int got_q;
    int got_r;
    vec_count  = 0;
    miss_count = 0;
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    do_div("25_3", 5'd25, 5'd3, 8, 1, 0, 5);
    do_div("31_1", 5'd31, 5'd1, 31, 0, 0, 5);
    do_div("7_9", 5'd7, 5'd9, 0, 7, 0, 5);
    do_div("12_0", 5'd12, 5'd0, 31, 12, 1, 0);
    do_div("12_4", 5'd12, 5'd4, 3, 0, 0, 5);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    dividend = 5'd25;
    divisor  = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 5'd30;
    divisor  = 5'd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    got_q    = -1;
    got_r    = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        got_q = quotient;
        got_r = remainder;
      end
    end
    check("ign_done_cnt", done_cnt, 1);
    check("ign_q", got_q, 8);
    check("ign_r", got_r, 1);

    // reset at step 3 discards the operation
    @(negedge clk);
    dividend = 5'd25;
    divisor  = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_q", quotient, 0);
    check("mrst_r", remainder, 0);
    check("mrst_dbz", div_by_zero, 0);
    rst      = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mrst_no_done", done_cnt, 0);
    do_div("19_6", 5'd19, 5'd6, 3, 1, 0, 5);

    // start held high: one done every 7 cycles, results stable between strobes
    @(negedge clk);
    dividend  = 5'd22;
    divisor   = 5'd5;
    start     = 1'b1;
    done_cnt  = 0;
    last_done = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (last_done >= 0) check("hold_period", i - last_done, 7);
        last_done = i;
      end
      if (done_cnt > 0) begin
        check("hold_q", quotient, 4);
        check("hold_r", remainder, 2);
      end
    end
    check("hold_done_cnt", done_cnt, 5);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
